// File: rtl/midi_tx.sv
// MIDI serial transmitter: pops bytes from an upstream fifo and sends
// 8N1 frames at CLKS_PER_BIT clocks per bit, back-to-back when data is waiting.
module midi_tx #(
  parameter int unsigned CLKS_PER_BIT = 384
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       fifo_empty,
  input  logic [7:0] data_i,
  output logic       stb_rd,
  output logic       tx,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q,   cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q,   bit_d;
  logic        tx_q,    tx_d;
  logic        stb_q,   stb_d;
  logic        load;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    stb_d   = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) load = 1'b1;
      end
      START: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = RELOAD;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = RELOAD;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Shared by the idle start and the back-to-back exit from the last stop cycle
    if (load) begin
      state_d = START;
      cnt_d   = RELOAD;
      shift_d = data_i;
      tx_d    = 1'b0;
      stb_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      stb_q   <= stb_d;
    end
  end

  assign tx     = tx_q;
  assign stb_rd = stb_q;
  assign busy   = (state_q != IDLE);

endmodule
